uart_tx: RTL

UART transmitter that serialises parallel words onto a single line, one frame per word. It is the sending counterpart of the team's `rx` receiver and uses the same framing and baud parameters, so the two can be looped back directly. Words are accepted over a valid/ready handshake. A one-word holding register lets the next word be accepted during a frame, so consecutive frames go out with no idle gap.

---
 rtl/uart_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// A one-word holding register lets frames go out back-to-back with no idle gap.
module uart_tx #(
    parameter int CLK_BAUD_RATIO = 868,
    parameter int DATA_SIZE      = 8,
    parameter int PARITY         = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx_out,
    output logic                 busy_out,
    output logic                 done_out
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam int CNT_W = $clog2(CLK_BAUD_RATIO);
    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_BAUD_RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLK_BAUD_RATIO - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_SIZE-1:0] shift, shift_nxt, hold;
    logic                 par_bit, hold_full;
    logic                 hs, bit_end;

    // Parity is fixed when the word enters the shift register.
    function automatic logic par_of(input logic [DATA_SIZE-1:0] w);
        return (PARITY == 2) ? ~(^w) : (^w);
    endfunction

    assign ready_out = !hold_full;
    assign hs        = valid_in && ready_out;
    assign bit_end   = (cnt == CNT_LAST);
    assign shift_nxt = shift >> 1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            hold      <= '0;
            par_bit   <= 1'b0;
            hold_full <= 1'b0;
            tx_out    <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            done_out <= (state == STOP) && (cnt == CNT_DONE);
            cnt      <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;

            // While busy, a word goes to the holding register unless the frame
            // is ending right now, in which case it is loaded straight away.
            if (hs && state != IDLE && !(state == STOP && bit_end)) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (hs) begin
                        shift    <= data_in;
                        par_bit  <= par_of(data_in);
                        state    <= START;
                        tx_out   <= 1'b0;
                        busy_out <= 1'b1;
                    end
                end
                START: if (bit_end) begin
                    state  <= DATA;
                    idx    <= '0;
                    tx_out <= shift[0];
                end
                DATA: if (bit_end) begin
                    shift <= shift_nxt;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state  <= PAR;
                            tx_out <= par_bit;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        tx_out <= shift_nxt[0];
                    end
                end
                PAR: if (bit_end) begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end
                STOP: if (bit_end) begin
                    if (hold_full) begin
                        shift     <= hold;
                        par_bit   <= par_of(hold);
                        hold_full <= 1'b0;
                        state     <= START;
                        tx_out    <= 1'b0;
                    end else if (hs) begin
                        shift   <= data_in;
                        par_bit <= par_of(data_in);
                        state   <= START;
                        tx_out  <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        tx_out   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
